regfile_legv8: RTL and testbench
================================

REGFILE_LEGV8 -- requirements
Module: regfile_legv8

Interface
REQ-001 SHALL have port: clock  in  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port: SA  in  5  read-port-A register index; drives ALU operand A.
REQ-004 SHALL have port: SB  in  5  read-port-B register index; drives ALU operand B.
REQ-005 SHALL have port: DA  in  5  write register index.
REQ-006 SHALL have port: D  in  64  write data; normally ALU result F or memory load data.
REQ-007 SHALL have port: W  in  1  write enable.
REQ-008 SHALL have port: A  out  64  read data for SA.
REQ-009 SHALL have port: B  out  64  read data for SB.
REQ-010 SHALL have port: status_in  in  4  ALU status {V,C,N,Z}.
REQ-011 SHALL have port: SF  in  1  set-flags enable, for ADDS/SUBS/ANDS-class operations.
REQ-012 SHALL have port: flags  out  4  registered NZCV, same bit order {V,C,N,Z}.

Function
REQ-013 SHALL hold 31 general registers X0..X30, each 64 bits.
REQ-014 Index 31 SHALL be XZR:
- reads of index 31 return 64'h0 on either port;
- writes to index 31 are discarded.
REQ-015 Reads SHALL be combinational: A and B follow SA/SB and stored contents in the same cycle (zero-cycle latency).
REQ-016 A write SHALL occur on the rising edge of clock when W=1, storing D into X[DA].
REQ-017 With W=0, no register SHALL change.
REQ-018 Both read ports SHALL operate independently; SA==SB returns identical data on A and B.
REQ-019 When SF=1, flags SHALL load status_in on the rising edge of clock; with SF=0, flags SHALL hold.
REQ-020 When W=1 and SF=1 in the same cycle, both updates SHALL occur on the same edge, independently.
REQ-021 Same-cycle read/write to the same non-31 index SHALL behave as defined in Configuration.
REQ-022 X/Z on DA with W=0 SHALL NOT corrupt state.

Reset
REQ-023 On reset_n=0, X0..X30 SHALL clear to 64'h0 and flags to 4'b0000 immediately, without waiting for a clock edge.
REQ-024 While reset_n=0, writes and flag loads SHALL be ignored.
REQ-025 During reset, A and B SHALL read 0 for every index.
REQ-026 Reset deassertion SHALL be synchronized externally.
REQ-027 The first write SHALL take effect on the first rising edge of clock with reset_n=1.
REQ-028 Reset asserted in the same cycle as W=1 SHALL win: the register reads 0 afterwards.

Configuration
REQ-029 Macro REGFILE_BYPASS_EN:
- defined: when W=1, DA!=31 and SA==DA (or SB==DA), the corresponding output SHALL equal D combinationally in that cycle (write-through);
- also defined: flags SHALL present status_in combinationally while SF=1.
REQ-030 Without REGFILE_BYPASS_EN, outputs SHALL show pre-write contents until after the edge.

Structure
REQ-031 Package legv8_pkg SHALL define:
- XLEN=64;
- NREG=32;
- ZR_IDX=31;
- status bit positions Z_BIT=0, N_BIT=1, C_BIT=2, V_BIT=3, shared with the ALU.
REQ-032 The flag register SHALL be a sub-module nzcv_reg (4-bit enable flop with async active-low clear, plus optional bypass mux).
REQ-033 The register array and read muxes SHALL reside in regfile_legv8.

Verification
REQ-034 Reset check: after reset, read all 32 indices on both ports -> all 64'h0; flags=4'b0000.
REQ-035 Write/read:
- W=1, DA=5, D=64'hDEADBEEF_01234567, one edge, W=0;
- then SA=5, SB=5 -> A=B=64'hDEADBEEF_01234567.
REQ-036 XZR:
- W=1, DA=31, D=64'hFFFF_FFFF_FFFF_FFFF;
- then SA=31 -> A=64'h0.
REQ-037 Same-cycle hazard:
- X7=64'h1; W=1, DA=7, D=64'h2, SA=7 before the edge;
- A=64'h2 with REGFILE_BYPASS_EN, A=64'h1 without;
- A=64'h2 after the edge in both builds.
REQ-038 Flags:
- status_in=4'b1010, SF=1, one edge -> flags=4'b1010;
- then status_in=4'b0101, SF=0, one edge -> flags stay 4'b1010.
REQ-039 Async reset mid-operation:
- X3=64'h55, flags=4'b1111;
- pulse reset_n low between edges -> X3 reads 0 and flags=0 before the next edge.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared LEGv8 datapath constants and types for the register file and ALU.
package legv8_pkg;

   localparam int unsigned XLEN   = 64;
   localparam int unsigned NREG   = 32;
   localparam int unsigned ZR_IDX = 31;
   localparam int unsigned IDX_W  = 5;

   // Status bit positions inside the {V,C,N,Z} nibble, shared with the ALU
   localparam int unsigned Z_BIT = 0;
   localparam int unsigned N_BIT = 1;
   localparam int unsigned C_BIT = 2;
   localparam int unsigned V_BIT = 3;

   typedef logic [XLEN-1:0]  xword_t;
   typedef logic [IDX_W-1:0] reg_idx_t;
   typedef logic [3:0]       nzcv_t;

   // True when the index names the hardwired zero register XZR
   function automatic logic is_zr(input reg_idx_t idx);
      return idx == reg_idx_t'(ZR_IDX);
   endfunction

endpackage

// File: rtl/regfile_legv8_if.sv
// Register-file access bundle: read/write indices, data, flag load and results.
interface regfile_legv8_if;
   import legv8_pkg::*;

   reg_idx_t SA;
   reg_idx_t SB;
   reg_idx_t DA;
   xword_t   D;
   logic     W;
   xword_t   A;
   xword_t   B;
   nzcv_t    status_in;
   logic     SF;
   nzcv_t    flags;

   modport master (
      output SA, SB, DA, D, W, status_in, SF,
      input  A, B, flags
   );

   modport slave (
      input  SA, SB, DA, D, W, status_in, SF,
      output A, B, flags
   );

endinterface

// File: rtl/nzcv_reg.sv
// NZCV flag register: 4-bit enable flop with async active-low clear.
// Optional write-through of status_in while SF=1 when REGFILE_BYPASS_EN is defined.
module nzcv_reg
   import legv8_pkg::*;
(
   input  logic  clock,
   input  logic  reset_n,
   input  logic  sf,
   input  nzcv_t status_in,
   output nzcv_t flags
);

   nzcv_t flags_q;

   // Load status on set-flags operations, otherwise hold
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         flags_q <= '0;
      end else if (sf) begin
         flags_q <= status_in;
      end
   end

   // Present stored flags, or the incoming status when bypass is built in
   always_comb begin
      flags = flags_q;
`ifdef REGFILE_BYPASS_EN
      if (reset_n && sf) begin
         flags = status_in;
      end
`endif
   end

endmodule

// File: rtl/regfile_legv8.sv
// LEGv8 register file: X0..X30 plus hardwired XZR (index 31), two
// combinational read ports, one write port and the NZCV flag register.
// Optional write-through bypass controlled by REGFILE_BYPASS_EN.
module regfile_legv8
   import legv8_pkg::*;
(
   input  logic            clock,
   input  logic            reset_n,
   regfile_legv8_if.slave  rf
);

   xword_t regs [NREG-1];
   xword_t a_rd;
   xword_t b_rd;

   // Register array: async clear, single write port, XZR writes dropped
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < NREG - 1; i++) begin
            regs[i] <= '0;
         end
      end else if (rf.W && !is_zr(rf.DA)) begin
         for (int unsigned i = 0; i < NREG - 1; i++) begin
            if (rf.DA == reg_idx_t'(i)) begin
               regs[i] <= rf.D;
            end
         end
      end
   end

   // Read muxes: index 31 falls through to zero; optional write-through
   always_comb begin
      a_rd = '0;
      b_rd = '0;
      for (int unsigned i = 0; i < NREG - 1; i++) begin
         if (rf.SA == reg_idx_t'(i)) begin
            a_rd = regs[i];
         end
         if (rf.SB == reg_idx_t'(i)) begin
            b_rd = regs[i];
         end
      end
`ifdef REGFILE_BYPASS_EN
      // reset_n gates the bypass so reads stay zero throughout reset
      if (reset_n && rf.W && !is_zr(rf.DA)) begin
         if (rf.SA == rf.DA) begin
            a_rd = rf.D;
         end
         if (rf.SB == rf.DA) begin
            b_rd = rf.D;
         end
      end
`endif
   end

   assign rf.A = a_rd;
   assign rf.B = b_rd;

   nzcv_reg u_nzcv (
      .clock     (clock),
      .reset_n   (reset_n),
      .sf        (rf.SF),
      .status_in (rf.status_in),
      .flags     (rf.flags)
   );

endmodule

// File: tb/tb_regfile_legv8.sv
// Directed self-checking bench for regfile_legv8.
module tb_regfile_legv8;
  import legv8_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  regfile_legv8_if rf_if ();

  regfile_legv8 dut (
    .clock   (clock),
    .reset_n (reset_n),
    .rf      (rf_if)
  );

  always #5 clock = ~clock;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic expect_flags(input string name, input logic [63:0] expv);
    logic [63:0] act;
    act = {60'h0, rf_if.flags};
    check_val(name, act, expv);
  endtask

  task automatic read_chk(input string name, input logic [4:0] sa, input logic [4:0] sb,
                          input logic [63:0] ea, input logic [63:0] eb);
    logic [63:0] act_a;
    logic [63:0] act_b;
    rf_if.SA = sa;
    rf_if.SB = sb;
    #1;
    act_a = rf_if.A;
    act_b = rf_if.B;
    check_val({name, "_A"}, act_a, ea);
    check_val({name, "_B"}, act_b, eb);
  endtask

  task automatic write_reg(input logic [4:0] idx, input logic [63:0] data);
    @(negedge clock);
    rf_if.W  = 1'b1;
    rf_if.DA = idx;
    rf_if.D  = data;
    @(posedge clock);
    #1;
    rf_if.W  = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rf_if.SA        = '0;
    rf_if.SB        = '0;
    rf_if.DA        = '0;
    rf_if.D         = '0;
    rf_if.W         = 1'b0;
    rf_if.status_in = '0;
    rf_if.SF        = 1'b0;

    // Reads during reset are zero even with a live write request
    #2;
    rf_if.W  = 1'b1;
    rf_if.DA = 5'd4;
    rf_if.D  = 64'hAAAA_AAAA_AAAA_AAAA;
    read_chk("rst_rd", 5'd4, 5'd4, 64'h0, 64'h0);
    rf_if.SF        = 1'b1;
    rf_if.status_in = 4'b1111;
    #1;
    expect_flags("rst_flags_ignored", 64'h0);
    @(posedge clock);
    @(posedge clock);
    #1;
    rf_if.W  = 1'b0;
    rf_if.SF = 1'b0;
    rf_if.status_in = '0;
    @(negedge clock);
    reset_n = 1'b1;
    #1;

    // Reset state: every index on both ports, plus flags
    for (int unsigned i = 0; i < 32; i++) begin
      rf_if.SA = 5'(i);
      rf_if.SB = 5'(31 - i);
      #1;
      checks++;
      if (rf_if.A !== 64'h0) begin
        errors++;
        $display("FAIL reset_sweep_A[%0d]: got %h", i, rf_if.A);
      end
      checks++;
      if (rf_if.B !== 64'h0) begin
        errors++;
        $display("FAIL reset_sweep_B[%0d]: got %h", i, rf_if.B);
      end
    end
    expect_flags("reset_flags", 64'h0);

    // Basic write then read on both ports
    write_reg(5'd5, 64'hDEADBEEF_01234567);
    read_chk("wr_x5", 5'd5, 5'd5, 64'hDEADBEEF_01234567, 64'hDEADBEEF_01234567);
    read_chk("x6_untouched", 5'd6, 5'd5, 64'h0, 64'hDEADBEEF_01234567);

    // Boundary registers X0 and X30
    write_reg(5'd0, 64'h0123_4567_89AB_CDEF);
    write_reg(5'd30, 64'h8000_0000_0000_0001);
    read_chk("x0_x30", 5'd0, 5'd30, 64'h0123_4567_89AB_CDEF, 64'h8000_0000_0000_0001);
    read_chk("x30_x5", 5'd30, 5'd5, 64'h8000_0000_0000_0001, 64'hDEADBEEF_01234567);

    // XZR write is discarded and reads zero
    write_reg(5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
    read_chk("xzr", 5'd31, 5'd31, 64'h0, 64'h0);
    read_chk("xzr_nbr", 5'd30, 5'd0, 64'h8000_0000_0000_0001, 64'h0123_4567_89AB_CDEF);

    // W=0 with an unknown index must leave state alone
    @(negedge clock);
    rf_if.W  = 1'b0;
    rf_if.DA = 'x;
    rf_if.D  = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clock);
    #1;
    rf_if.DA = '0;
    read_chk("w0_hold", 5'd5, 5'd0, 64'hDEADBEEF_01234567, 64'h0123_4567_89AB_CDEF);

    // Same-cycle read/write hazard on X7
    write_reg(5'd7, 64'h1);
    @(negedge clock);
    rf_if.W  = 1'b1;
    rf_if.DA = 5'd7;
    rf_if.D  = 64'h2;
    read_chk("hazard_pre", 5'd7, 5'd8, BYP ? 64'h2 : 64'h1, 64'h0);
    read_chk("hazard_pre_b", 5'd8, 5'd7, 64'h0, BYP ? 64'h2 : 64'h1);
    @(posedge clock);
    #1;
    rf_if.W = 1'b0;
    read_chk("hazard_post", 5'd7, 5'd7, 64'h2, 64'h2);

    // Write to XZR never bypasses
    @(negedge clock);
    rf_if.W  = 1'b1;
    rf_if.DA = 5'd31;
    rf_if.D  = 64'hFFFF_FFFF_FFFF_FFFF;
    read_chk("xzr_bypass", 5'd31, 5'd31, 64'h0, 64'h0);
    @(posedge clock);
    #1;
    rf_if.W = 1'b0;

    // Flag load and hold
    @(negedge clock);
    rf_if.status_in = 4'b1010;
    rf_if.SF        = 1'b1;
    #1;
    expect_flags("flags_pre", BYP ? 64'hA : 64'h0);
    @(posedge clock);
    #1;
    expect_flags("flags_load", 64'hA);
    @(negedge clock);
    rf_if.status_in = 4'b0101;
    rf_if.SF        = 1'b0;
    #1;
    expect_flags("flags_sf0_pre", 64'hA);
    @(posedge clock);
    #1;
    expect_flags("flags_hold", 64'hA);

    // Write and flag load on the same edge
    @(negedge clock);
    rf_if.W         = 1'b1;
    rf_if.DA        = 5'd9;
    rf_if.D         = 64'hCAFE_F00D_1234_5678;
    rf_if.SF        = 1'b1;
    rf_if.status_in = 4'b1111;
    @(posedge clock);
    #1;
    rf_if.W         = 1'b0;
    rf_if.SF        = 1'b0;
    rf_if.status_in = 4'b0000;
    read_chk("w_sf_same", 5'd9, 5'd7, 64'hCAFE_F00D_1234_5678, 64'h2);
    expect_flags("w_sf_flags", 64'hF);

    // Async reset pulse between edges
    write_reg(5'd3, 64'h55);
    read_chk("x3_pre_rst", 5'd3, 5'd9, 64'h55, 64'hCAFE_F00D_1234_5678);
    @(negedge clock);
    #1;
    reset_n = 1'b0;
    read_chk("async_rst_low", 5'd3, 5'd9, 64'h0, 64'h0);
    expect_flags("async_rst_flags", 64'h0);
    reset_n = 1'b1;
    read_chk("async_rst_rel", 5'd3, 5'd5, 64'h0, 64'h0);
    expect_flags("async_rst_flags_rel", 64'h0);

    // Reset wins over a concurrent write
    @(negedge clock);
    rf_if.W  = 1'b1;
    rf_if.DA = 5'd4;
    rf_if.D  = 64'h77;
    #1;
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    // First edge after release must accept a write
    @(negedge clock);
    reset_n  = 1'b1;
    rf_if.W  = 1'b1;
    rf_if.DA = 5'd12;
    rf_if.D  = 64'h0ABC;
    read_chk("rst_win_x4", 5'd4, 5'd12, 64'h0, BYP ? 64'h0ABC : 64'h0);
    @(posedge clock);
    #1;
    rf_if.W = 1'b0;
    read_chk("first_write", 5'd12, 5'd4, 64'h0ABC, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
